// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered RV32I instruction-decode stage. Extracts rs1/rs2/
//                rd, the sign-extended immediate and register-use flags, flags
//                illegal encodings and carries the PC from fetch to execute.
//                Valid/ready handshakes on both sides. With SKID=1 a 2-entry
//                skid buffer makes ready_o a registered signal so that the
//                execute-side ready never reaches fetch combinationally.
//  Parameters  : RV32E       1: a used register index >= 16 is illegal
//                CHECK_FUNCT 1: reserved funct3/funct7 and instr[1:0]!=2'b11
//                               are illegal
//                SKID        1: output reg + skid reg, registered ready_o
//                            0: output reg only, ready_o = ready_i | ~valid_o
//  Ports       : clk, rstn_i (async, active-low), flush_i
//                fetch side   : valid_i, ready_o, instr_i[31:0], pc_i[31:0]
//                execute side : valid_o, ready_i, pc_o, rs1_o, rs2_o, rd_o,
//                               rs1_used_o, rs2_used_o, imm_o, invalid_o
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage #(
    parameter int unsigned RV32E       = 0,
    parameter int unsigned CHECK_FUNCT = 1,
    parameter int unsigned SKID        = 1
) (
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        flush_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] pc_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        rs1_used_o,
    output logic        rs2_used_o,
    output logic [31:0] imm_o,
    output logic        invalid_o
);

    // Major opcodes, instr[6:2]; instr[1:0] is checked separately.
    localparam logic [4:0] c_OPC_LOAD   = 5'b00000;
    localparam logic [4:0] c_OPC_FENCE  = 5'b00011;
    localparam logic [4:0] c_OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] c_OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] c_OPC_STORE  = 5'b01000;
    localparam logic [4:0] c_OPC_OP     = 5'b01100;
    localparam logic [4:0] c_OPC_LUI    = 5'b01101;
    localparam logic [4:0] c_OPC_BRANCH = 5'b11000;
    localparam logic [4:0] c_OPC_JALR   = 5'b11001;
    localparam logic [4:0] c_OPC_JAL    = 5'b11011;
    localparam logic [4:0] c_OPC_SYSTEM = 5'b11100;

    localparam logic [6:0] c_F7_ZERO = 7'h00;
    localparam logic [6:0] c_F7_ALT  = 7'h20;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1_used;
        logic        rs2_used;
        logic [31:0] imm;
        logic        invalid;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------------
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_u;
    logic        w_bad_funct;
    entry_t      w_dec;
    entry_t      r_out;

    assign w_f3    = instr_i[14:12];
    assign w_f7    = instr_i[31:25];
    assign w_imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
    assign w_imm_u = {instr_i[31:12], 12'b0};

    always_comb begin
        w_dec       = '0;
        w_dec.pc    = pc_i;
        w_bad_funct = 1'b0;
        case (instr_i[6:2])
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_dec.rd  = instr_i[11:7];
                w_dec.imm = w_imm_u;
            end
            c_OPC_JAL: begin
                w_dec.rd  = instr_i[11:7];
                w_dec.imm = w_imm_j;
            end
            c_OPC_JALR: begin
                w_dec.rs1      = instr_i[19:15];
                w_dec.rs1_used = 1'b1;
                w_dec.rd       = instr_i[11:7];
                w_dec.imm      = w_imm_i;
                w_bad_funct    = (w_f3 != 3'd0);
            end
            c_OPC_LOAD: begin
                w_dec.rs1      = instr_i[19:15];
                w_dec.rs1_used = 1'b1;
                w_dec.rd       = instr_i[11:7];
                w_dec.imm      = w_imm_i;
                w_bad_funct    = (w_f3 == 3'd3) || (w_f3 == 3'd6) || (w_f3 == 3'd7);
            end
            c_OPC_OPIMM: begin
                w_dec.rs1      = instr_i[19:15];
                w_dec.rs1_used = 1'b1;
                w_dec.rd       = instr_i[11:7];
                w_dec.imm      = w_imm_i;
                // Only the shift encodings constrain the upper immediate bits.
                w_bad_funct    = ((w_f3 == 3'd1) && (w_f7 != c_F7_ZERO)) ||
                                 ((w_f3 == 3'd5) && (w_f7 != c_F7_ZERO) && (w_f7 != c_F7_ALT));
            end
            c_OPC_OP: begin
                w_dec.rs1      = instr_i[19:15];
                w_dec.rs2      = instr_i[24:20];
                w_dec.rs1_used = 1'b1;
                w_dec.rs2_used = 1'b1;
                w_dec.rd       = instr_i[11:7];
                // funct7=0x20 exists only for SUB (f3=0) and SRA (f3=5).
                w_bad_funct    = ((w_f7 != c_F7_ZERO) && (w_f7 != c_F7_ALT)) ||
                                 ((w_f7 == c_F7_ALT) && (w_f3 != 3'd0) && (w_f3 != 3'd5));
            end
            c_OPC_STORE: begin
                w_dec.rs1      = instr_i[19:15];
                w_dec.rs2      = instr_i[24:20];
                w_dec.rs1_used = 1'b1;
                w_dec.rs2_used = 1'b1;
                w_dec.imm      = w_imm_s;
                w_bad_funct    = (w_f3 > 3'd2);
            end
            c_OPC_BRANCH: begin
                w_dec.rs1      = instr_i[19:15];
                w_dec.rs2      = instr_i[24:20];
                w_dec.rs1_used = 1'b1;
                w_dec.rs2_used = 1'b1;
                w_dec.imm      = w_imm_b;
                w_bad_funct    = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            end
            c_OPC_FENCE, c_OPC_SYSTEM: begin
                // Passed through as legal with no register or immediate fields.
            end
            default: begin
                w_dec.invalid = 1'b1;
            end
        endcase

        if ((CHECK_FUNCT != 0) && (w_bad_funct || (instr_i[1:0] != 2'b11))) begin
            w_dec.invalid = 1'b1;
        end

        // rd is already zero when unused, so only the source flags need gating.
        if ((RV32E != 0) && ((w_dec.rs1_used && w_dec.rs1[4]) ||
                             (w_dec.rs2_used && w_dec.rs2[4]) || w_dec.rd[4])) begin
            w_dec.invalid = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Handshake / storage
    // ------------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_skid
            state_t r_state;
            state_t w_state_nxt;
            entry_t r_skid;
            logic   w_accept;
            logic   w_deliver;
            logic   w_load_out_in;
            logic   w_load_out_skid;
            logic   w_load_skid;

            assign w_accept  = valid_i & (r_state != S_SKID);
            assign w_deliver = ready_i & (r_state != S_EMPTY);

            always_ff @(posedge clk or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_state <= S_EMPTY;
                end else begin
                    r_state <= w_state_nxt;
                end
            end

            always_comb begin
                w_state_nxt     = r_state;
                w_load_out_in   = 1'b0;
                w_load_out_skid = 1'b0;
                w_load_skid     = 1'b0;
                if (flush_i) begin
                    w_state_nxt = S_EMPTY;
                end else begin
                    case (r_state)
                        S_EMPTY: begin
                            if (w_accept) begin
                                w_state_nxt   = S_FULL;
                                w_load_out_in = 1'b1;
                            end
                        end
                        S_FULL: begin
                            if (w_accept && w_deliver) begin
                                w_load_out_in = 1'b1;
                            end else if (w_accept) begin
                                w_state_nxt = S_SKID;
                                w_load_skid = 1'b1;
                            end else if (w_deliver) begin
                                w_state_nxt = S_EMPTY;
                            end
                        end
                        S_SKID: begin
                            if (w_deliver) begin
                                w_state_nxt     = S_FULL;
                                w_load_out_skid = 1'b1;
                            end
                        end
                        default: begin
                            w_state_nxt = S_EMPTY;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_out  <= '0;
                    r_skid <= '0;
                end else begin
                    if (w_load_out_in) begin
                        r_out <= w_dec;
                    end else if (w_load_out_skid) begin
                        r_out <= r_skid;
                    end
                    if (w_load_skid) begin
                        r_skid <= w_dec;
                    end
                end
            end

            // Derived purely from the state register: no path from ready_i.
            assign ready_o = (r_state != S_SKID);
            assign valid_o = (r_state != S_EMPTY);
        end else begin : g_noskid
            logic r_valid;
            logic w_accept;

            assign ready_o  = ready_i | ~r_valid;
            assign w_accept = valid_i & ready_o;

            always_ff @(posedge clk or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_valid <= 1'b0;
                    r_out   <= '0;
                end else if (flush_i) begin
                    r_valid <= 1'b0;
                end else if (w_accept) begin
                    r_valid <= 1'b1;
                    r_out   <= w_dec;
                end else if (ready_i) begin
                    r_valid <= 1'b0;
                end
            end

            assign valid_o = r_valid;
        end
    endgenerate

    assign pc_o       = r_out.pc;
    assign rs1_o      = r_out.rs1;
    assign rs2_o      = r_out.rs2;
    assign rd_o       = r_out.rd;
    assign rs1_used_o = r_out.rs1_used;
    assign rs2_used_o = r_out.rs2_used;
    assign imm_o      = r_out.imm;
    assign invalid_o  = r_out.invalid;

endmodule
`default_nettype wire
